// File: rtl/luces_pkg.sv
// Shared types and constants for the ping-pong light bus monitor.
package luces_pkg;

  localparam int unsigned LUCES_WIDTH = 8;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } luces_state_e;

endpackage

// File: rtl/luces_if.sv
// Light bus plus monitor status, seen from the bus driver (master) and the monitor (slave).
interface luces_if
  import luces_pkg::*;
#(
  parameter int WIDTH = LUCES_WIDTH,
  parameter int CNT_W = 8
);
  localparam int PW = $clog2(WIDTH);

  logic             ENABLE;
  logic             CLR;
  logic [WIDTH-1:0] LEDG;
  logic [PW-1:0]    POS;
  logic             DIR;
  logic             VALID;
  logic             LOCKED;
  logic             ERROR;
  logic [CNT_W-1:0] SWEEPS;

  modport master (
    output ENABLE, CLR, LEDG,
    input  POS, DIR, VALID, LOCKED, ERROR, SWEEPS
  );

  modport slave (
    input  ENABLE, CLR, LEDG,
    output POS, DIR, VALID, LOCKED, ERROR, SWEEPS
  );
endinterface

// File: rtl/luces_onehot_decode.sv
// Combinational one-hot decoder: index of the set bit, valid only when exactly one bit is set.
module luces_onehot_decode
  import luces_pkg::*;
#(
  parameter int WIDTH = LUCES_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [IDX_W-1:0] index,
  output logic             valid
);
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] NONE = {WIDTH{1'b0}};

  // Highest set bit wins; only meaningful when valid.
  always_comb begin
    index = {IDX_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      index = bits[i] ? IDX_W'(i) : index;
    end
    valid = (bits != NONE) && ((bits & (bits - ONE)) == NONE);
  end
endmodule

// File: rtl/luces_monitor.sv
// Receiving-end checker for the ping-pong light bus: locks onto a legal bouncing
// sweep, counts completed round trips and flags violations seen while locked.
module luces_monitor
  import luces_pkg::*;
#(
  parameter int WIDTH      = LUCES_WIDTH,
  parameter int LOCK_STEPS = 3,
  parameter int CNT_W      = 8
) (
  input logic    CLK,
  input logic    RSTn,
  luces_if.slave bus
);
  localparam int            PW       = $clog2(WIDTH);
  localparam logic [PW-1:0] POS_TOP  = PW'(WIDTH - 1);
  localparam logic [PW-1:0] POS_BOT  = {PW{1'b0}};
  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [3:0]    LOCK_CNT = 4'(LOCK_STEPS);

  luces_state_e     state_r, state_s;
  logic [PW-1:0]    pos_r, pos_s, idx_s;
  logic             dir_r, dir_s, known_r, known_s;
  logic             valid_r, valid_s, locked_r, locked_s, error_r, error_s;
  logic [3:0]       cnt_r, cnt_s;
  logic [CNT_W-1:0] sweeps_r, sweeps_s;
  logic             hot_s, up_ok_s, dn_ok_s, legal_s, new_dir_s;

  luces_onehot_decode #(.WIDTH(WIDTH), .IDX_W(PW)) u_decode (
    .bits  (bus.LEDG),
    .index (idx_s),
    .valid (hot_s)
  );

  // Legality of the sampled position and the direction it leaves us in; at an end the bounce is taken immediately.
  always_comb begin
    up_ok_s = (pos_r != POS_TOP) && (idx_s == pos_r + POS_ONE);
    dn_ok_s = (pos_r != POS_BOT) && (idx_s == pos_r - POS_ONE);
    legal_s = known_r ? ((dir_r == DOWN) ? dn_ok_s : up_ok_s) : (up_ok_s || dn_ok_s);
    if (idx_s == POS_TOP) begin
      new_dir_s = DOWN;
    end else if (idx_s == POS_BOT) begin
      new_dir_s = UP;
    end else begin
      new_dir_s = dn_ok_s ? DOWN : UP;
    end
  end

  // Tracking FSM next state and next register values.
  always_comb begin
    state_s  = state_r;
    pos_s    = pos_r;
    dir_s    = dir_r;
    known_s  = known_r;
    cnt_s    = cnt_r;
    valid_s  = valid_r;
    locked_s = locked_r;
    error_s  = error_r;
    sweeps_s = sweeps_r;
    if (bus.CLR) begin
      state_s  = IDLE;
      pos_s    = {PW{1'b0}};
      dir_s    = UP;
      known_s  = 1'b0;
      cnt_s    = 4'd0;
      valid_s  = 1'b0;
      locked_s = 1'b0;
      error_s  = 1'b0;
      sweeps_s = {CNT_W{1'b0}};
    end else if (bus.ENABLE) begin
      valid_s = hot_s;
      case (state_r)
        IDLE, FAULT: begin
          if (hot_s) begin
            state_s = ACQUIRE;
            pos_s   = idx_s;
            known_s = 1'b0;
            cnt_s   = 4'd0;
          end else begin
            state_s = state_r;
          end
        end
        ACQUIRE: begin
          if (!hot_s) begin
            state_s = IDLE;
          end else if (legal_s) begin
            pos_s   = idx_s;
            dir_s   = new_dir_s;
            known_s = 1'b1;
            cnt_s   = cnt_r + 4'd1;
            if (cnt_s == LOCK_CNT) begin
              state_s  = LOCKED;
              locked_s = 1'b1;
            end else begin
              state_s = ACQUIRE;
            end
          end else begin
            pos_s   = idx_s;
            known_s = 1'b0;
            cnt_s   = 4'd0;
          end
        end
        LOCKED: begin
          if (hot_s && legal_s) begin
            pos_s = idx_s;
            dir_s = new_dir_s;
            if (idx_s == POS_BOT) begin
              sweeps_s = sweeps_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              sweeps_s = sweeps_r;
            end
          end else begin
            state_s  = FAULT;
            locked_s = 1'b0;
            error_s  = 1'b1;
            pos_s    = hot_s ? idx_s : pos_r;
          end
        end
        default: begin
          state_s  = IDLE;
          locked_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r  <= IDLE;
      pos_r    <= {PW{1'b0}};
      dir_r    <= UP;
      known_r  <= 1'b0;
      cnt_r    <= 4'd0;
      valid_r  <= 1'b0;
      locked_r <= 1'b0;
      error_r  <= 1'b0;
      sweeps_r <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_s;
      pos_r    <= pos_s;
      dir_r    <= dir_s;
      known_r  <= known_s;
      cnt_r    <= cnt_s;
      valid_r  <= valid_s;
      locked_r <= locked_s;
      error_r  <= error_s;
      sweeps_r <= sweeps_s;
    end
  end

  assign bus.POS    = pos_r;
  assign bus.DIR    = dir_r;
  assign bus.VALID  = valid_r;
  assign bus.LOCKED = locked_r;
  assign bus.ERROR  = error_r;
  assign bus.SWEEPS = sweeps_r;
endmodule

// File: tb/tb_luces_monitor.sv
// Randomized bench for luces_monitor against a sweep-history reference model.
module tb_luces_monitor;
  localparam int W  = 8;
  localparam int LS = 3;

  logic         clk    = 1'b0;
  logic         rstn   = 1'b0;
  logic         enable = 1'b0;
  logic         clr    = 1'b0;
  logic [W-1:0] ledg   = '0;

  luces_if #(.WIDTH(W), .CNT_W(8)) bus_a ();
  luces_if #(.WIDTH(W), .CNT_W(2)) bus_b ();

  assign bus_a.ENABLE = enable;
  assign bus_a.CLR    = clr;
  assign bus_a.LEDG   = ledg;
  assign bus_b.ENABLE = enable;
  assign bus_b.CLR    = clr;
  assign bus_b.LEDG   = ledg;

  luces_monitor #(.WIDTH(W), .LOCK_STEPS(LS), .CNT_W(8)) dut_a (.CLK(clk), .RSTn(rstn), .bus(bus_a));
  luces_monitor #(.WIDTH(W), .LOCK_STEPS(LS), .CNT_W(2)) dut_b (.CLK(clk), .RSTn(rstn), .bus(bus_b));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: the current run of positions, trimmed to two once locked
  int   run[$];
  logic m_locked, m_error, m_valid, m_dir;
  int   m_pos, m_sweeps;

  // generator model
  int   gen_pos;
  logic gen_dir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] oh(input int p);
    logic [W-1:0] v;
    v = W'(1);
    return v << p;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0; m_error = 1'b0; m_valid = 1'b0; m_dir = 1'b0;
    m_pos = 0; m_sweeps = 0;
    run.delete();
  endtask

  task automatic model_step(input logic en, input logic cl, input logic [W-1:0] l);
    int idx, last, prev;
    bit ext;
    if (cl) begin
      model_reset();
      return;
    end
    if (!en) return;
    m_valid = ($countones(l) == 1);
    if (!m_valid) begin
      if (m_locked) begin
        m_locked = 1'b0;
        m_error  = 1'b1;
      end
      run.delete();
      return;
    end
    idx = 0;
    for (int i = 0; i < W; i++) if (l[i]) idx = i;
    m_pos = idx;
    if (run.size() == 0) begin
      run.push_back(idx);
      return;
    end
    last = run[$];
    ext  = (idx - last == 1) || (last - idx == 1);
    if (ext && run.size() >= 2 && last != 0 && last != W - 1) begin
      prev = run[$-1];
      ext  = (idx - last == last - prev);
    end
    if (!ext) begin
      run.delete();
      if (m_locked) begin
        m_locked = 1'b0;
        m_error  = 1'b1;
      end else begin
        run.push_back(idx);
      end
      return;
    end
    run.push_back(idx);
    m_dir = (idx == W - 1) ? 1'b1 : (idx == 0) ? 1'b0 : (idx < last);
    if (m_locked) begin
      if (idx == 0) m_sweeps++;
      while (run.size() > 2) void'(run.pop_front());
    end else if (run.size() == LS + 1) begin
      m_locked = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("POS",      32'(bus_a.POS),    32'(m_pos));
    chk("DIR",      32'(bus_a.DIR),    32'(m_dir));
    chk("VALID",    32'(bus_a.VALID),  32'(m_valid));
    chk("LOCKED",   32'(bus_a.LOCKED), 32'(m_locked));
    chk("ERROR",    32'(bus_a.ERROR),  32'(m_error));
    chk("SWEEPS",   32'(bus_a.SWEEPS), 32'(m_sweeps % 256));
    chk("SWEEPS_2", 32'(bus_b.SWEEPS), 32'(m_sweeps % 4));
    chk("LOCKED_2", 32'(bus_b.LOCKED), 32'(m_locked));
  endtask

  task automatic cyc(input logic en, input logic cl, input logic [W-1:0] l);
    enable = en; clr = cl; ledg = l;
    @(posedge clk);
    #1;
    model_step(en, cl, l);
    check_all();
  endtask

  task automatic gen_adv();
    if (gen_pos == W - 1) gen_dir = 1'b1;
    else if (gen_pos == 0) gen_dir = 1'b0;
    gen_pos = gen_dir ? gen_pos - 1 : gen_pos + 1;
  endtask

  // asynchronous reset pulse placed between clock edges
  task automatic async_reset();
    #3 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_async_locked", 32'(bus_a.LOCKED), 32'd0);
    chk("rst_async_sweeps", 32'(bus_a.SWEEPS), 32'd0);
    #2 rstn = 1'b1;
  endtask

  initial begin
    int seq[6];
    int r;
    logic en;
    logic [W-1:0] l;

    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check_all();
    rstn = 1'b1;

    // lock and one full round trip
    gen_pos = 0; gen_dir = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cyc(1'b1, 1'b0, oh(gen_pos));
      if (k == 2)  chk("no_lock_3rd", 32'(bus_a.LOCKED), 32'd0);
      if (k == 3)  chk("lock_4th", 32'(bus_a.LOCKED), 32'd1);
      if (k == 7)  chk("dir_at_top", 32'(bus_a.DIR), 32'd1);
      if (k == 14) begin
        chk("sweep_one", 32'(bus_a.SWEEPS), 32'd1);
        chk("dir_at_bottom", 32'(bus_a.DIR), 32'd0);
      end
      gen_adv();
    end

    // glitch while locked, then recover
    cyc(1'b1, 1'b0, 8'b0001_1000);
    chk("glitch_error", 32'(bus_a.ERROR), 32'd1);
    chk("glitch_unlock", 32'(bus_a.LOCKED), 32'd0);
    for (int p = 2; p <= 5; p++) cyc(1'b1, 1'b0, oh(p));
    chk("relock", 32'(bus_a.LOCKED), 32'd1);
    chk("error_sticky", 32'(bus_a.ERROR), 32'd1);

    // clear while locked with error, CLR beats ENABLE
    cyc(1'b1, 1'b1, oh(6));
    chk("clr_locked", 32'(bus_a.LOCKED), 32'd0);
    chk("clr_error", 32'(bus_a.ERROR), 32'd0);
    chk("clr_pos", 32'(bus_a.POS), 32'd0);
    chk("clr_valid", 32'(bus_a.VALID), 32'd0);

    // stall mid-sweep, then a repeated position
    gen_pos = 0; gen_dir = 1'b0;
    repeat (6) begin
      cyc(1'b1, 1'b0, oh(gen_pos));
      gen_adv();
    end
    repeat (5) begin
      cyc(1'b0, 1'b0, W'($urandom));
      chk("stall_pos", 32'(bus_a.POS), 32'd5);
      chk("stall_locked", 32'(bus_a.LOCKED), 32'd1);
    end
    cyc(1'b1, 1'b0, oh(5));
    chk("repeat_error", 32'(bus_a.ERROR), 32'd1);
    chk("repeat_unlock", 32'(bus_a.LOCKED), 32'd0);

    // acquire restart after a jump
    cyc(1'b0, 1'b1, '0);
    seq = '{2, 3, 5, 6, 7, 6};
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, oh(seq[k]));
      if (k == 2) chk("restart_no_lock", 32'(bus_a.LOCKED), 32'd0);
      if (k == 4) chk("restart_not_yet", 32'(bus_a.LOCKED), 32'd0);
      if (k == 5) chk("restart_lock", 32'(bus_a.LOCKED), 32'd1);
    end

    // five round trips while locked: narrow counter wraps
    gen_pos = 6; gen_dir = 1'b1;
    gen_adv();
    repeat (70) begin
      cyc(1'b1, 1'b0, oh(gen_pos));
      gen_adv();
    end
    chk("wrap_narrow", 32'(bus_b.SWEEPS), 32'd1);
    chk("wrap_wide", 32'(bus_a.SWEEPS), 32'd5);

    // asynchronous reset mid-sweep
    async_reset();

    // randomized traffic: legal sweeps with glitches, jumps, repeats, stalls, clears
    gen_pos = int'($urandom_range(0, W - 1));
    gen_dir = 1'($urandom_range(0, 1));
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 3) != 0);
      r  = int'($urandom_range(0, 199));
      l  = oh(gen_pos);
      if (r < 4) begin
        l = W'($urandom);
      end else if (r < 8) begin
        gen_pos = int'($urandom_range(0, W - 1));
        gen_dir = 1'($urandom_range(0, 1));
        l = oh(gen_pos);
      end
      cyc(en, (r == 199), l);
      if (en && r >= 8 && r < 196) gen_adv();
      if ($urandom_range(0, 799) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
